// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the board's single asynchronous 16-bit SRAM between three requesters:
// the CPU data port (D), the CPU instruction-fetch port (I) and the graphics
// frame reader (G). One access runs at a time through a fixed sequence:
//
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE
//
// A request first seen in IDLE at edge t is acknowledged in cycle
// t+2+WAIT_CYCLES. Back-to-back transfers take 3+WAIT_CYCLES cycles each.
//
// Parameters
//   WAIT_CYCLES : ACCESS-state cycles per transfer, legal range 1..15
//   ADDR_W      : SRAM address width
//   DATA_W      : SRAM data width (the board bus is 16 bits)
//
// Ports
//   clk, rst                 : clock and synchronous active-high reset
//   dReq/dWe/dAddr/dWdata    : data port request (read or write)
//   dAck                     : one-cycle completion pulse for D
//   iReq/iAddr, iAck         : instruction-fetch read port
//   gReq/gAddr, gAck         : graphics read port
//   rdata                    : read data of the acked transfer; it is valid in
//                              the ack cycle and holds until the next read
//                              completes
//   busy                     : high in every state except IDLE
//   memAddrBus               : SRAM address pins
//   memDataBus               : SRAM data pins, high-Z except while writing
//   memEnable/memRead/memWrite : SRAM CE#, OE#, WE# (all active low)
//
// Build option
//   SRAM_ARB_ROUND_ROBIN_EN  : when defined, grant priority rotates through
//                              D, I, G. A 2-bit pointer names the preferred
//                              requester. When undefined, priority is fixed
//                              D > I > G and there is no pointer register.
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,

  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,

  input  logic              gReq,
  input  logic [ADDR_W-1:0] gAddr,
  output logic              gAck,

  output logic [DATA_W-1:0] rdata,
  output logic              busy,

  output logic [ADDR_W-1:0] memAddrBus,
  inout  wire  [DATA_W-1:0] memDataBus,
  output logic              memEnable,
  output logic              memRead,
  output logic              memWrite
);

  localparam int CNT_W = 4;

  // Requester indices, shared by the grant logic, the owner register and the
  // round-robin pointer.
  localparam logic [1:0] SEL_D = 2'd0;
  localparam logic [1:0] SEL_I = 2'd1;
  localparam logic [1:0] SEL_G = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT              state;
  stateT              stateNext;

  logic [2:0]         reqVec;
  logic               anyReq;
  logic               grant;
  logic [1:0]         grantSel;
  logic               grantWe;
  logic [ADDR_W-1:0]  grantAddr;
  logic [DATA_W-1:0]  grantWdata;

  logic [1:0]         owner;
  logic               weLatch;
  logic [ADDR_W-1:0]  addrLatch;
  logic [DATA_W-1:0]  wdataLatch;
  logic [CNT_W-1:0]   waitCnt;
  logic [DATA_W-1:0]  rdataReg;
  logic               lastAccess;
  logic               driveBus;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [1:0]         rrPtr;

  // The pointer names the first requester to consider. The search then wraps
  // D -> I -> G -> D. A pointer value of 3 is unreachable and is treated as D.
  function automatic logic [1:0] pickRoundRobin(input logic [2:0] req,
                                                input logic [1:0] ptr);
    logic [1:0] sel;
    sel = SEL_D;
    unique case (ptr)
      SEL_I:   sel = req[1] ? SEL_I : (req[2] ? SEL_G : SEL_D);
      SEL_G:   sel = req[2] ? SEL_G : (req[0] ? SEL_D : SEL_I);
      default: sel = req[0] ? SEL_D : (req[1] ? SEL_I : SEL_G);
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] nextPtr(input logic [1:0] sel);
    return (sel == SEL_G) ? SEL_D : sel + 2'd1;
  endfunction
`else
  function automatic logic [1:0] pickFixed(input logic [2:0] req);
    logic [1:0] sel;
    if (req[0])      sel = SEL_D;
    else if (req[1]) sel = SEL_I;
    else             sel = SEL_G;
    return sel;
  endfunction
`endif

  // ---- Arbitration: choose a requester and mux its request fields ----------
  always_comb begin
    reqVec = {gReq, iReq, dReq};
    anyReq = |reqVec;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    grantSel = pickRoundRobin(reqVec, rrPtr);
`else
    grantSel = pickFixed(reqVec);
`endif
    // I and G are read-only, so only D can supply a write enable.
    grantWe    = 1'b0;
    grantAddr  = dAddr;
    grantWdata = dWdata;
    unique case (grantSel)
      SEL_D:   grantWe   = dWe;
      SEL_I:   grantAddr = iAddr;
      SEL_G:   grantAddr = gAddr;
      default: grantAddr = dAddr;
    endcase
  end

  assign grant      = (state == IDLE) && anyReq;
  assign lastAccess = (state == ACCESS) && (waitCnt == '0);

  // ---- FSM state register -------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyReq) stateNext = SETUP;
      SETUP:   stateNext = ACCESS;
      ACCESS:  if (waitCnt == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---- Grant capture, wait counter, read-data capture ----------------------
  // The address and the read data are board-visible, so they take the reset
  // values. An abandoned transfer therefore leaves no stale address on the
  // pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= SEL_D;
      weLatch   <= 1'b0;
      addrLatch <= '0;
      waitCnt   <= '0;
      rdataReg  <= '0;
    end else begin
      if (grant) begin
        owner     <= grantSel;
        weLatch   <= grantWe;
        addrLatch <= grantAddr;
      end
      // Load in SETUP so that ACCESS runs for exactly WAIT_CYCLES cycles and
      // ends with the counter at zero.
      if (state == SETUP)
        waitCnt <= CNT_W'(WAIT_CYCLES - 1);
      else if ((state == ACCESS) && (waitCnt != '0))
        waitCnt <= waitCnt - 1'b1;
      // Sample at the end of the final ACCESS cycle. OE# has then been low
      // for the full programmed access time.
      if (lastAccess && !weLatch)
        rdataReg <= memDataBus;
    end
  end

  // Write data is only observable while it is driven during SETUP/ACCESS. It
  // needs no reset.
  always_ff @(posedge clk) begin
    if (grant) wdataLatch <= grantWdata;
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)        rrPtr <= SEL_D;
    else if (grant) rrPtr <= nextPtr(grantSel);
  end
`endif

  // ---- Pin decode from the registered state --------------------------------
  // WE# is held off in SETUP, so address and data settle before the write
  // strobe. The bus is released in DONE, so a following read's SETUP never
  // meets a driven bus.
  always_comb begin
    memEnable = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    driveBus  = 1'b0;
    dAck      = 1'b0;
    iAck      = 1'b0;
    gAck      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      SETUP: begin
        memEnable = 1'b0;
        memRead   = weLatch;
        driveBus  = weLatch;
      end
      ACCESS: begin
        memEnable = 1'b0;
        memRead   = weLatch;
        memWrite  = ~weLatch;
        driveBus  = weLatch;
      end
      DONE: begin
        dAck = (owner == SEL_D);
        iAck = (owner == SEL_I);
        gAck = (owner == SEL_G);
      end
      default: begin
        memEnable = 1'b1;
      end
    endcase
  end

  assign memAddrBus = addrLatch;
  assign memDataBus = driveBus ? wdataLatch : {DATA_W{1'bz}};
  assign rdata      = rdataReg;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. Three requester processes issue transfers.
// - Directed: single read, single write, three-way contention, a held D
//   request competing with G, and a reset during a write.
// - Random: transfers with randomised gaps, addresses and data.
// Each issued request is pushed onto a per-port queue together with its
// expected read data. The expected data comes from a bench-side memory image.
// A monitor replays the arbitration rules at the transaction level: who wins
// when the arbiter is free, how many cycles each phase lasts and what the pins
// must show in each phase. It pops and checks each transfer when its ack
// appears.
// - An SRAM model answers reads while OE# and CE# are low.
// - A bus keeper drives a fixed probe word whenever CE# is high. A released
//   bus therefore reads back as that word.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int WC = 1;
  localparam int AW = 18;
  localparam logic [15:0] PROBE = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dReq = 1'b0, dWe = 1'b0, iReq = 1'b0, gReq = 1'b0;
  logic [AW-1:0] dAddr = '0, iAddr = '0, gAddr = '0;
  logic [15:0]   dWdata = '0;
  logic          dAck, iAck, gAck, busy, memEnable, memRead, memWrite;
  logic [15:0]   rdata;
  logic [AW-1:0] memAddrBus;
  wire  [15:0]   memDataBus;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   exp;
  } reqRec;

  reqRec dQ[$];
  reqRec iQ[$];
  reqRec gQ[$];
  logic [15:0] refMem [int];
  logic [15:0] sramMem [0:(1<<AW)-1];

  sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(AW), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dAck(dAck),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck),
    .gReq(gReq), .gAddr(gAddr), .gAck(gAck),
    .rdata(rdata), .busy(busy),
    .memAddrBus(memAddrBus), .memDataBus(memDataBus),
    .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM answers reads; the keeper drives the probe word while CE# is high.
  wire        tbOe  = memEnable || !memRead;
  wire [15:0] tbVal = memEnable ? PROBE : sramMem[memAddrBus];
  assign memDataBus = tbOe ? tbVal : 16'bz;

  function automatic logic [15:0] initVal(input int a);
    if (a == 16) return 16'hBEEF;
    return 16'(a * 40503) ^ 16'h3C96;
  endfunction

  function automatic logic [15:0] refRead(input int a);
    if (refMem.exists(a)) return refMem[a];
    return initVal(a);
  endfunction

  initial begin : sramModel
    for (int a = 0; a < (1 << AW); a++) sramMem[a] = initVal(a);
    forever begin
      @(posedge clk);
      if (!memEnable && !memWrite) sramMem[memAddrBus] = memDataBus;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at posedge+#1. Pushes the expected outcome and raises the request.
  task automatic issue(input int port, input logic we, input logic [AW-1:0] a,
                       input logic [15:0] wd);
    reqRec r;
    r.we = we;
    r.addr = a;
    r.wdata = wd;
    r.exp = we ? 16'h0000 : refRead(int'(a));
    case (port)
      0: begin dWe = we; dAddr = a; dWdata = wd; dReq = 1'b1; dQ.push_back(r); end
      1: begin iAddr = a; iReq = 1'b1; iQ.push_back(r); end
      default: begin gAddr = a; gReq = 1'b1; gQ.push_back(r); end
    endcase
  endtask

  task automatic drop(input int port);
    case (port)
      0: dReq = 1'b0;
      1: iReq = 1'b0;
      default: gReq = 1'b0;
    endcase
  endtask

  task automatic waitAck(input int port, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = (port == 0) ? dAck : ((port == 1) ? iAck : gAck);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL ackTimeout: port %0d got no ack, expected one within 400 cycles", port);
    end
  endtask

  // Issues n transfers on one port. Gaps are random (0 = re-request in the
  // cycle right after the ack). Address regions keep D writes away from I/G
  // reads, so every expected read value is known when it is issued.
  task automatic burst(input int port, input int n, input int gapMax);
    bit ok;
    logic we;
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      case (port)
        0: begin we = 1'($urandom_range(0, 1)); a = AW'(32'h20000 + $urandom_range(0, 'h1F)); end
        1: begin we = 1'b0; a = AW'(32'h00100 + $urandom_range(0, 'hFF)); end
        default: begin we = 1'b0; a = AW'(32'h10000 + $urandom_range(0, 'hFFFF)); end
      endcase
      issue(port, we, a, 16'($urandom));
      waitAck(port, ok);
      @(posedge clk); #1;
      drop(port);
      repeat ($urandom_range(0, gapMax)) begin @(posedge clk); #1; end
    end
  endtask

  function automatic reqRec frontRec(input int p);
    reqRec r;
    r = '0;
    case (p)
      0: if (dQ.size() != 0) r = dQ[0];
      1: if (iQ.size() != 0) r = iQ[0];
      default: if (gQ.size() != 0) r = gQ[0];
    endcase
    return r;
  endfunction

  function automatic int qSize(input int p);
    return (p == 0) ? dQ.size() : ((p == 1) ? iQ.size() : gQ.size());
  endfunction

  function automatic void popRec(input int p);
    case (p)
      0: if (dQ.size() != 0) void'(dQ.pop_front());
      1: if (iQ.size() != 0) void'(iQ.pop_front());
      default: if (gQ.size() != 0) void'(gQ.pop_front());
    endcase
  endfunction

  // Winner among pending requests; search starts at ptr and wraps D, I, G.
  function automatic int pickWinner(input logic [2:0] p, input int ptr);
    for (int k = 0; k < 3; k++)
      if (p[(ptr + k) % 3]) return (ptr + k) % 3;
    return 0;
  endfunction

  // Transaction-level monitor. Phases are counted from the negedge where the
  // grant was sampled: 1 = SETUP, 2..1+WC = ACCESS, 2+WC = DONE (ack).
  initial begin : monitor
    bit            busyM = 1'b0;
    int            gCyc = 0, win = 0, ptr = 0, stage;
    reqRec         cur = '0;
    bit            inAcc, fixPending = 1'b0;
    logic [AW-1:0] fixAddr = '0;
    logic [2:0]    expAck;
    logic          expEn, expRd, expWr;
    @(posedge clk);
    @(posedge clk);
    forever begin
      @(negedge clk);
      stage  = cyc - gCyc;
      inAcc  = busyM && stage >= 1 && stage <= 1 + WC;
      expEn  = !inAcc;
      expRd  = !(inAcc && !cur.we);
      expWr  = !(busyM && stage >= 2 && stage <= 1 + WC && cur.we);
      expAck = (busyM && stage == 2 + WC) ? 3'(1 << win) : 3'b000;
      check("pins{g,i,dAck,busy,en,rd,wr}",
            {gAck, iAck, dAck, busy, memEnable, memRead, memWrite},
            {expAck, busyM, expEn, expRd, expWr});
      if (inAcc && cur.we) check("busWriteData", memDataBus, cur.wdata);
      else if (expEn)      check("busReleased", memDataBus, PROBE);
      // A torn write may or may not have reached the array; the SRAM model's
      // content is taken as the truth for that address from here on.
      if (fixPending) begin
        refMem[int'(fixAddr)] = sramMem[fixAddr];
        fixPending = 1'b0;
      end
      if (rst) begin
        if (busyM) begin
          popRec(win);
          if (cur.we) begin fixPending = 1'b1; fixAddr = cur.addr; end
        end
        busyM = 1'b0;
        ptr = 0;
      end else if (busyM) begin
        if (stage == 2 + WC) begin
          if (cur.we) begin
            check("sramWritten", sramMem[cur.addr], cur.wdata);
            refMem[int'(cur.addr)] = cur.wdata;
          end else begin
            check("rdata", rdata, cur.exp);
          end
          popRec(win);
          busyM = 1'b0;
        end
      end else if ({gReq, iReq, dReq} != 3'b000) begin
        win = pickWinner({gReq, iReq, dReq}, ptr);
        check("grantHasRecord", 32'(qSize(win) != 0), 32'd1);
        cur = frontRec(win);
        gCyc = cyc;
        busyM = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ptr = (win + 1) % 3;
`endif
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resetRdata", rdata, 32'h0);
    check("resetAddr", memAddrBus, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch read of 0x00010 (SRAM holds 0xBEEF there).
    issue(1, 1'b0, 18'h00010, 16'h0000);
    waitAck(1, ok);
    @(posedge clk); #1; drop(1);

    // Single write to the top address, then read it back.
    issue(0, 1'b1, 18'h3FFFF, 16'h1234);
    waitAck(0, ok);
    @(posedge clk); #1; drop(0);
    issue(0, 1'b0, 18'h3FFFF, 16'h0000);
    waitAck(0, ok);
    @(posedge clk); #1; drop(0);

    // All three requesters raise their requests at the same edge.
    fork
      burst(0, 1, 0);
      burst(1, 1, 0);
      burst(2, 1, 0);
    join

    // D re-requests right after every ack while G waits.
    fork
      burst(0, 4, 0);
      begin
        issue(2, 1'b0, 18'h10040, 16'h0000);
        t0 = cyc;
        waitAck(2, ok);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        check("gAckWithin8", 32'((cyc - t0) <= 8), 32'd1);
`endif
        @(posedge clk); #1; drop(2);
      end
    join

    // Reset during ACCESS of a write to 0x00005, then read it back.
    issue(0, 1'b1, 18'h00005, 16'hA55A);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #1;
      ok = !memWrite;
    end
    check("writeReachedAccess", 32'(ok), 32'd1);
    rst = 1'b1;
    drop(0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midResetRdata", rdata, 32'h0);
    check("midResetAddr", memAddrBus, 32'h0);
    @(posedge clk); #1;
    issue(0, 1'b0, 18'h00005, 16'h0000);
    waitAck(0, ok);
    @(posedge clk); #1; drop(0);

    // Random traffic on all ports.
    fork
      burst(0, 40, 3);
      burst(1, 40, 3);
      burst(2, 40, 3);
    join

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
